// File: rtl/rename_free_list.sv
// Free list for the 48-entry physical register file: grants up to four of the
// lowest free tags per cycle to rename and takes back up to four tags from commit.
module rename_free_list (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req_count,
    input  logic [2:0] i_ret_count,
    input  logic [5:0] i_ret_p0,
    input  logic [5:0] i_ret_p1,
    input  logic [5:0] i_ret_p2,
    input  logic [5:0] i_ret_p3,
    output logic [5:0] o_req0,
    output logic [5:0] o_req1,
    output logic [5:0] o_req2,
    output logic [5:0] o_req3,
    output logic [2:0] o_req_count,
    output logic [5:0] o_avail_count
);

    localparam int NUM_TAGS = 48;

    logic [NUM_TAGS-1:0] free_q;
    logic [NUM_TAGS-1:0] free_d;
    logic [NUM_TAGS-1:0] alloc_mask;
    logic [NUM_TAGS-1:0] ret_mask;
    logic [2:0]          req_clamp;
    logic [2:0]          ret_clamp;
    logic [2:0]          grant_n;
    logic [5:0]          grant_tag [4];
    logic [5:0]          ret_tag   [4];
    logic [5:0]          avail;

    assign req_clamp = (i_req_count > 3'd4) ? 3'd4 : i_req_count;
    assign ret_clamp = (i_ret_count > 3'd4) ? 3'd4 : i_ret_count;

    assign ret_tag[0] = i_ret_p0;
    assign ret_tag[1] = i_ret_p1;
    assign ret_tag[2] = i_ret_p2;
    assign ret_tag[3] = i_ret_p3;

    // Priority scan from tag 0 upward picks the lowest free tags in order.
    always_comb begin
        alloc_mask = '0;
        grant_n    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            grant_tag[i] = '0;
        end
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (free_q[t] && (grant_n < req_clamp)) begin
                grant_tag[grant_n[1:0]] = 6'(t);
                alloc_mask[t]           = 1'b1;
                grant_n                 = grant_n + 3'd1;
            end
        end
    end

    // Out-of-range tags never match any t, so they drop out naturally.
    always_comb begin
        ret_mask = '0;
        for (int p = 0; p < 4; p++) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if ((3'(p) < ret_clamp) && (ret_tag[p] == 6'(t))) begin
                    ret_mask[t] = 1'b1;
                end
            end
        end
    end

    // A granted tag was already free, so a same-cycle return of it is a no-op.
    assign free_d = (free_q | ret_mask) & ~alloc_mask;

    always_comb begin
        avail = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            avail = avail + 6'(free_q[t]);
        end
    end

    assign o_avail_count = avail;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            free_q      <= {{16{1'b1}}, {32{1'b0}}};
            o_req0      <= '0;
            o_req1      <= '0;
            o_req2      <= '0;
            o_req3      <= '0;
            o_req_count <= '0;
        end else begin
            free_q      <= free_d;
            o_req0      <= grant_tag[0];
            o_req1      <= grant_tag[1];
            o_req2      <= grant_tag[2];
            o_req3      <= grant_tag[3];
            o_req_count <= grant_n;
        end
    end

endmodule

// File: tb/tb_rename_free_list.sv
// Table-driven bench for rename_free_list with an expected-result queue.
module tb_rename_free_list;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [2:0] i_req_count;
    logic [2:0] i_ret_count;
    logic [5:0] i_ret_p0, i_ret_p1, i_ret_p2, i_ret_p3;
    logic [5:0] o_req0, o_req1, o_req2, o_req3;
    logic [2:0] o_req_count;
    logic [5:0] o_avail_count;

    int checks = 0;
    int errors = 0;

    rename_free_list dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_count  (i_req_count),
        .i_ret_count  (i_ret_count),
        .i_ret_p0     (i_ret_p0),
        .i_ret_p1     (i_ret_p1),
        .i_ret_p2     (i_ret_p2),
        .i_ret_p3     (i_ret_p3),
        .o_req0       (o_req0),
        .o_req1       (o_req1),
        .o_req2       (o_req2),
        .o_req3       (o_req3),
        .o_req_count  (o_req_count),
        .o_avail_count(o_avail_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] rc;
        logic [5:0] p [4];
        logic [2:0] e_cnt;
        logic [5:0] e_tag [4];
        logic [5:0] e_avail;
    } vec_t;

    typedef struct {
        logic [2:0] cnt;
        logic [5:0] tag [4];
        logic [5:0] avail;
    } exp_t;

    vec_t vecs [$];
    exp_t sb   [$];

    function automatic vec_t v(input logic rst, input logic [2:0] req, input logic [2:0] rc,
                               input logic [5:0] p0, input logic [5:0] p1,
                               input logic [5:0] p2, input logic [5:0] p3,
                               input logic [2:0] ec,
                               input logic [5:0] e0, input logic [5:0] e1,
                               input logic [5:0] e2, input logic [5:0] e3,
                               input logic [5:0] ea);
        vec_t r;
        r.rst = rst; r.req = req; r.rc = rc;
        r.p[0] = p0; r.p[1] = p1; r.p[2] = p2; r.p[3] = p3;
        r.e_cnt = ec;
        r.e_tag[0] = e0; r.e_tag[1] = e1; r.e_tag[2] = e2; r.e_tag[3] = e3;
        r.e_avail = ea;
        return r;
    endfunction

    task automatic check(input string name, input int step, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int step);
        exp_t e;
        exp_t got;
        i_rst       = x.rst;
        i_req_count = x.req;
        i_ret_count = x.rc;
        i_ret_p0    = x.p[0];
        i_ret_p1    = x.p[1];
        i_ret_p2    = x.p[2];
        i_ret_p3    = x.p[3];
        e.cnt   = x.e_cnt;
        e.tag   = x.e_tag;
        e.avail = x.e_avail;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", step, 0, 1);
        end else begin
            got = sb.pop_front();
            check("req_count", step, int'(o_req_count), int'(got.cnt));
            check("req0", step, int'(o_req0), int'(got.tag[0]));
            check("req1", step, int'(o_req1), int'(got.tag[1]));
            check("req2", step, int'(o_req2), int'(got.tag[2]));
            check("req3", step, int'(o_req3), int'(got.tag[3]));
            check("avail", step, int'(o_avail_count), int'(got.avail));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset / idle / exhaustion
        vecs.push_back(v(1, 4, 4, 1, 2, 3, 4,  0,  0,  0,  0,  0, 16));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 16));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  4, 32, 33, 34, 35, 12));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  4, 36, 37, 38, 39,  8));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  4, 40, 41, 42, 43,  4));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  4, 44, 45, 46, 47,  0));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
        // Return while empty, then partial grant in ascending order
        vecs.push_back(v(0, 4, 2, 40, 5, 0, 0, 0,  0,  0,  0,  0,  2));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  2,  5, 40,  0,  0,  0));
        // Clamp of request count
        vecs.push_back(v(0, 0, 4, 32, 33, 34, 35, 0, 0, 0, 0, 0,  4));
        vecs.push_back(v(0, 7, 0, 0, 0, 0, 0,  4, 32, 33, 34, 35,  0));
        // Only ports below i_ret_count count; already-free and out-of-range are ignored
        vecs.push_back(v(0, 0, 3, 10, 11, 12, 13, 0, 0, 0, 0, 0,  3));
        vecs.push_back(v(0, 0, 2, 10, 50, 0, 0, 0,  0,  0,  0,  0,  3));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  1, 10,  0,  0,  0,  2));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  2, 11, 12,  0,  0,  0));
        // Same-cycle grant and return: returned tag not grantable yet
        vecs.push_back(v(0, 0, 2, 20, 21, 0, 0, 0,  0,  0,  0,  0,  2));
        vecs.push_back(v(0, 1, 1, 22, 0, 0, 0, 1, 20,  0,  0,  0,  2));
        vecs.push_back(v(0, 4, 0, 0, 0, 0, 0,  2, 21, 22,  0,  0,  0));
        // Duplicate returns across ports
        vecs.push_back(v(0, 0, 4, 7, 7, 7, 8,  0,  0,  0,  0,  0,  2));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0,  2,  7,  8,  0,  0,  0));
        // Mid-operation reset with activity on both sides
        vecs.push_back(v(1, 4, 4, 1, 2, 3, 4,  0,  0,  0,  0,  0, 16));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  1, 32,  0,  0,  0, 15));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 15));

        foreach (vecs[i]) apply(vecs[i], i);

        // Fill the list completely: 15 free now (33..47); return 0..31 then 32
        for (int k = 0; k < 8; k++) begin
            apply(v(0, 0, 4, 6'(4*k), 6'(4*k+1), 6'(4*k+2), 6'(4*k+3),
                    0, 0, 0, 0, 0, 6'(15 + 4*(k+1))), 100 + k);
        end
        apply(v(0, 0, 1, 32, 0, 0, 0, 0, 0, 0, 0, 0, 48), 110);
        apply(v(0, 0, 4, 0, 1, 2, 3, 0, 0, 0, 0, 0, 48), 111);
        apply(v(0, 4, 0, 0, 0, 0, 0, 4, 0, 1, 2, 3, 44), 112);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
